// File: rtl/fetch_queue_pkg.sv
// Shared constants and types for the instruction fetch queue.
// InstAddrBus / InstBus are the default address and instruction widths.
package fetch_queue_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;
  localparam int PC_INC      = 4;
  localparam int ENTRY_W     = InstAddrBus + InstBus;

  // What a taken redirect does to the queue contents and the fetch PC
  typedef enum logic [2:0] {
    REDIR_NONE,
    REDIR_FLUSH,
    REDIR_KEEP_QUEUED,
    REDIR_KEEP_INFLIGHT,
    REDIR_FETCH_SUCC
  } redir_e;

endpackage

// File: rtl/fq_ram.sv
// Circular register array holding {pc, inst} entries for the fetch queue.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// With FETCH_QUEUE_DELAY_SLOT_EN defined, also exposes the pc of the entry
// behind the head so the parent can tell whether a delay slot is queued.
module fq_ram
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = ENTRY_W
`ifdef FETCH_QUEUE_DELAY_SLOT_EN
  , parameter int TAG_W = InstAddrBus
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     trunc,
  input  logic                     keep,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             head_data,
`ifdef FETCH_QUEUE_DELAY_SLOT_EN
  output logic [TAG_W-1:0]         next_tag,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW:0]   head_q, head_d;
  logic [AW:0]   tail_q, tail_d;
  logic [AW:0]   tail_base;

  // Pointer update; a truncate rebases the tail just behind the kept entries
  always_comb begin
    head_d    = head_q + PW'(pop);
    tail_base = trunc ? (head_d + PW'(keep)) : tail_q;
    tail_d    = tail_base + PW'(push);
    mem_d     = mem_q;
    if (push) begin
      mem_d[tail_base[AW-1:0]] = wdata;
    end
  end

  // Pointers clear asynchronously so occupancy drops to zero at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Entry storage needs no reset; outputs are qualified by occupancy
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign count     = tail_q - head_q;
  assign head_data = mem_q[head_q[AW-1:0]];

`ifdef FETCH_QUEUE_DELAY_SLOT_EN
  logic [AW-1:0] next_idx;
  assign next_idx = head_q[AW-1:0] + AW'(1);
  assign next_tag = mem_q[next_idx][W-1:W-TAG_W];
`endif

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential ROM fetches, buffers
// {pc, inst} pairs and presents the head to decode.
// Macro FETCH_QUEUE_DELAY_SLOT_EN: when defined a redirect keeps the MIPS
// branch delay slot (popped pc + 4); otherwise a redirect flushes everything.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int              ADDR_W   = InstAddrBus,
  parameter int              INST_W   = InstBus,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   rom_ce,
  output logic [ADDR_W-1:0]      rom_addr,
  input  logic [INST_W-1:0]      rom_inst,
  input  logic                   stall,
  input  logic                   branch_flag,
  input  logic [ADDR_W-1:0]      branch_target,
  output logic                   id_valid,
  output logic [ADDR_W-1:0]      id_pc,
  output logic [INST_W-1:0]      id_inst,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = CW + 1;
  localparam int EW = ADDR_W + INST_W;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic [ADDR_W-1:0] pending_target_q, pending_target_d;
  logic              inflight_q, inflight_d;
  logic              pending_q, pending_d;
  logic              push, pop, trunc, keep, redirect;
  logic [EW-1:0]     head_data;
  logic [ADDR_W-1:0] head_pc;
  logic [ADDR_W-1:0] succ_pc;
  logic [OW-1:0]     occupancy;
  redir_e            redir_kind;
`ifdef FETCH_QUEUE_DELAY_SLOT_EN
  logic [ADDR_W-1:0] next_tag;
`endif

  assign head_pc   = head_data[EW-1:INST_W];
  assign succ_pc   = head_pc + ADDR_W'(PC_INC);
  assign id_valid  = (count != '0);
  assign id_pc     = id_valid ? head_pc : '0;
  assign id_inst   = id_valid ? head_data[INST_W-1:0] : '0;
  assign pop       = id_valid && !stall;
  assign redirect  = pop && branch_flag;
  assign occupancy = {1'b0, count} + OW'(inflight_q);
  assign rom_ce    = rst && !redirect && (occupancy < OW'(DEPTH));
  assign rom_addr  = rom_ce ? pc_q : '0;

  // Decide how a redirect treats the popped instruction's successor
  always_comb begin
    redir_kind = REDIR_NONE;
    if (redirect) begin
`ifdef FETCH_QUEUE_DELAY_SLOT_EN
      if ((count >= CW'(2)) && (next_tag == succ_pc)) begin
        redir_kind = REDIR_KEEP_QUEUED;
      end else if (inflight_q && (inflight_pc_q == succ_pc)) begin
        redir_kind = REDIR_KEEP_INFLIGHT;
      end else begin
        redir_kind = REDIR_FETCH_SUCC;
      end
`else
      redir_kind = REDIR_FLUSH;
`endif
    end
  end

  // Fetch PC, in-flight tracking, queue write control and pending redirect
  always_comb begin
    pc_d             = pc_q;
    inflight_d       = rom_ce;
    inflight_pc_d    = rom_ce ? pc_q : inflight_pc_q;
    pending_d        = pending_q;
    pending_target_d = pending_target_q;
    push             = inflight_q;
    trunc            = 1'b0;
    keep             = 1'b0;
    if (rom_ce) begin
      if (pending_q) begin
        pc_d      = pending_target_q;
        pending_d = 1'b0;
      end else begin
        pc_d = pc_q + ADDR_W'(PC_INC);
      end
    end
    case (redir_kind)
      REDIR_FLUSH: begin
        trunc     = 1'b1;
        push      = 1'b0;
        pending_d = 1'b0;
        pc_d      = branch_target;
      end
      REDIR_KEEP_QUEUED: begin
        trunc     = 1'b1;
        keep      = 1'b1;
        push      = 1'b0;
        pending_d = 1'b0;
        pc_d      = branch_target;
      end
      REDIR_KEEP_INFLIGHT: begin
        trunc     = 1'b1;
        pending_d = 1'b0;
        pc_d      = branch_target;
      end
      REDIR_FETCH_SUCC: begin
        trunc            = 1'b1;
        push             = 1'b0;
        pending_d        = 1'b1;
        pending_target_d = branch_target;
        pc_d             = succ_pc;
      end
      default: ;
    endcase
  end

  // Control state; reset drops any in-flight response and pending redirect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q             <= RESET_PC;
      inflight_q       <= 1'b0;
      inflight_pc_q    <= '0;
      pending_q        <= 1'b0;
      pending_target_q <= '0;
    end else begin
      pc_q             <= pc_d;
      inflight_q       <= inflight_d;
      inflight_pc_q    <= inflight_pc_d;
      pending_q        <= pending_d;
      pending_target_q <= pending_target_d;
    end
  end

  fq_ram #(
    .DEPTH (DEPTH),
    .W     (EW)
`ifdef FETCH_QUEUE_DELAY_SLOT_EN
    , .TAG_W (ADDR_W)
`endif
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .trunc     (trunc),
    .keep      (keep),
    .wdata     ({inflight_pc_q, rom_inst}),
    .head_data (head_data),
`ifdef FETCH_QUEUE_DELAY_SLOT_EN
    .next_tag  (next_tag),
`endif
    .count     (count)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH 4) plus a second
// instance with RESET_PC 0xFFFFFFF8 to exercise address wrap.
// The ROM model returns the bitwise inverse of the requested address.
module tb_fetch_queue;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branchFlag;
  logic [31:0] branchTarget;
  logic        romCe;
  logic [31:0] romAddr;
  logic [31:0] romInst;
  logic        idValid;
  logic [31:0] idPc;
  logic [31:0] idInst;
  logic [2:0]  count;

  logic        romCeHi;
  logic [31:0] romAddrHi;
  logic [31:0] romInstHi;
  logic        idValidHi;
  logic [31:0] idPcHi;
  logic [31:0] idInstHi;
  logic [2:0]  countHi;

  int checkCount = 0;
  int errorCount = 0;
  int maxCount;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .rom_ce        (romCe),
    .rom_addr      (romAddr),
    .rom_inst      (romInst),
    .stall         (stall),
    .branch_flag   (branchFlag),
    .branch_target (branchTarget),
    .id_valid      (idValid),
    .id_pc         (idPc),
    .id_inst       (idInst),
    .count         (count)
  );

  fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dutHi (
    .clk           (clk),
    .rst           (rst),
    .rom_ce        (romCeHi),
    .rom_addr      (romAddrHi),
    .rom_inst      (romInstHi),
    .stall         (1'b0),
    .branch_flag   (1'b0),
    .branch_target (32'h0),
    .id_valid      (idValidHi),
    .id_pc         (idPcHi),
    .id_inst       (idInstHi),
    .count         (countHi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle ROM latency
  always @(posedge clk) begin
    romInst   <= ~romAddr;
    romInstHi <= ~romAddrHi;
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic bf, input logic [31:0] tgt);
    @(negedge clk);
    stall        = s;
    branchFlag   = bf;
    branchTarget = tgt;
    #1;
  endtask

  task automatic resetDut(input logic s);
    @(negedge clk);
    rst        = 1'b0;
    stall      = s;
    branchFlag = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst          = 1'b0;
    stall        = 1'b0;
    branchFlag   = 1'b0;
    branchTarget = 32'h0;
    #2;
    checkOutput("reset rom_ce", romCe, 0);
    checkOutput("reset rom_addr", romAddr, 0);
    checkOutput("reset id_valid", idValid, 0);
    checkOutput("reset id_pc", idPc, 0);
    checkOutput("reset id_inst", idInst, 0);
    checkOutput("reset count", count, 0);
    checkOutput("reset hi rom_addr", romAddrHi, 0);

    // Reset release, free-running fetch
    resetDut(1'b0);
    checkOutput("c0 rom_ce", romCe, 1);
    checkOutput("c0 rom_addr", romAddr, 32'h0);
    checkOutput("c0 hi rom_addr", romAddrHi, 32'hFFFF_FFF8);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("c1 rom_addr", romAddr, 32'h4);
    checkOutput("c1 hi rom_addr", romAddrHi, 32'hFFFF_FFFC);
    checkOutput("c1 id_valid", idValid, 0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("c2 rom_addr", romAddr, 32'h8);
    checkOutput("c2 hi rom_addr", romAddrHi, 32'h0);
    checkOutput("c2 id_pc", idPc, 32'h0);
    checkOutput("c2 id_inst", idInst, 32'hFFFF_FFFF);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("c3 id_pc", idPc, 32'h4);
    checkOutput("c3 count", count, 1);

    // Stall fill, release, then redirect on pop of 0x8
    resetDut(1'b1);
    maxCount = 0;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      if (int'(count) > maxCount) maxCount = int'(count);
    end
    checkOutput("stall max count", maxCount, 4);
    checkOutput("stall count", count, 4);
    checkOutput("stall rom_ce", romCe, 0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("rel0 id_pc", idPc, 32'h0);
    checkOutput("rel0 rom_ce", romCe, 0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("rel1 id_pc", idPc, 32'h4);
    checkOutput("rel1 rom_addr", romAddr, 32'h10);
    applyStimulus(1'b0, 1'b1, 32'h100);
    checkOutput("br id_pc", idPc, 32'h8);
    checkOutput("br rom_ce", romCe, 0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("br+1 rom_addr", romAddr, 32'h100);
`ifdef FETCH_QUEUE_DELAY_SLOT_EN
    checkOutput("br+1 count", count, 1);
    checkOutput("br+1 id_pc", idPc, 32'hC);
    checkOutput("br+1 id_inst", idInst, 32'hFFFF_FFF3);
`else
    checkOutput("br+1 count", count, 0);
    checkOutput("br+1 id_valid", idValid, 0);
`endif
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("br+2 count", count, 0);
    checkOutput("br+2 rom_addr", romAddr, 32'h104);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("br+3 id_pc", idPc, 32'h100);
    checkOutput("br+3 id_inst", idInst, 32'hFFFF_FEFF);

    // Redirect with only 0x8 queued (successor in flight)
    resetDut(1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h100);
    checkOutput("br2 id_pc", idPc, 32'h8);
    checkOutput("br2 count", count, 1);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("br2+1 rom_addr", romAddr, 32'h100);
`ifdef FETCH_QUEUE_DELAY_SLOT_EN
    checkOutput("br2+1 id_pc", idPc, 32'hC);
`else
    checkOutput("br2+1 id_valid", idValid, 0);
`endif
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("br2+2 id_valid", idValid, 0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("br2+3 id_pc", idPc, 32'h100);

    // Asynchronous reset mid-stream with three entries queued
    resetDut(1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("mid count before", count, 3);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("mid rom_ce", romCe, 0);
    checkOutput("mid rom_addr", romAddr, 0);
    checkOutput("mid id_valid", idValid, 0);
    checkOutput("mid id_pc", idPc, 0);
    checkOutput("mid id_inst", idInst, 0);
    checkOutput("mid count", count, 0);
    @(negedge clk);
    stall = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("restart rom_addr", romAddr, 32'h0);
    checkOutput("restart rom_ce", romCe, 1);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("restart+1 count", count, 0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("restart+2 id_pc", idPc, 32'h0);
    checkOutput("restart+2 id_inst", idInst, 32'hFFFF_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
